// File: rtl/ext_mem_responder_if.sv
// Command/response bundle between a delay-line initiator and the
// sample-memory responder.
interface ext_mem_responder_if #(
  parameter int DWIDTH = 16,
  parameter int AWIDTH = 15
);
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic              cmd_write_i;
  logic [AWIDTH-1:0] cmd_addr_i;
  logic [DWIDTH-1:0] cmd_wdata_i;
  logic              rd_valid_o;
  logic              rd_ready_i;
  logic [DWIDTH-1:0] rd_data_o;
  logic              init_done_o;

  modport master (
    output cmd_valid_i,
    output cmd_write_i,
    output cmd_addr_i,
    output cmd_wdata_i,
    output rd_ready_i,
    input  cmd_ready_o,
    input  rd_valid_o,
    input  rd_data_o,
    input  init_done_o
  );

  modport slave (
    input  cmd_valid_i,
    input  cmd_write_i,
    input  cmd_addr_i,
    input  cmd_wdata_i,
    input  rd_ready_i,
    output cmd_ready_o,
    output rd_valid_o,
    output rd_data_o,
    output init_done_o
  );
endinterface

// File: rtl/ext_mem_responder.sv
// On-chip RAM responder: clears RAM after reset, then serves reads and
// writes with credit-limited in-order read responses.
module ext_mem_responder #(
  parameter int DWIDTH       = 16,
  parameter int AWIDTH       = 15,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic clk_i,
  input  logic srst_n_i,
  ext_mem_responder_if.slave bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {
    CLEAR,
    SERVE
  } state_t;

  state_t            state;
  logic [AWIDTH-1:0] clear_addr;
  logic              ready;
  logic              init_done;
  logic [CW-1:0]     credits;
  logic [CW-1:0]     credits_nxt;

  logic              rd_acc;
  logic              wr_acc;
  logic              pop;
  logic              push;
  logic [DWIDTH-1:0] rd_word;
  logic [DWIDTH-1:0] push_data;

  logic [DWIDTH-1:0] mem [2**AWIDTH];
  logic [DWIDTH-1:0] fifo [FIFO_DEPTH];
  logic [PW-1:0]     wp;
  logic [PW-1:0]     rp;
  logic [CW-1:0]     cnt;

  assign rd_acc  = bus.cmd_valid_i && ready && !bus.cmd_write_i;
  assign wr_acc  = bus.cmd_valid_i && ready && bus.cmd_write_i;
  assign pop     = (cnt != '0) && bus.rd_ready_i;
  assign rd_word = mem[bus.cmd_addr_i];

  assign bus.cmd_ready_o = ready;
  assign bus.rd_valid_o  = (cnt != '0);
  assign bus.rd_data_o   = fifo[rp];
  assign bus.init_done_o = init_done;

  // RAM: zero-fill sweep during CLEAR, command writes afterwards
  always_ff @(posedge clk_i) begin
    if (state == CLEAR) begin
      mem[clear_addr] <= '0;
    end else if (wr_acc) begin
      mem[bus.cmd_addr_i] <= bus.cmd_wdata_i;
    end
  end

  // Credits cover words in the read pipeline plus FIFO occupancy
  always_comb begin
    credits_nxt = credits;
    if (rd_acc && !pop) begin
      credits_nxt = credits + CW'(1);
    end else if (!rd_acc && pop) begin
      credits_nxt = credits - CW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      state      <= CLEAR;
      clear_addr <= '0;
      ready      <= 1'b0;
      init_done  <= 1'b0;
      credits    <= '0;
    end else begin
      credits <= credits_nxt;
      unique case (state)
        CLEAR: begin
          clear_addr <= clear_addr + 1'b1;
          if (clear_addr == '1) begin
            state     <= SERVE;
            init_done <= 1'b1;
            ready     <= 1'b1;
          end
        end
        SERVE: begin
          ready <= (credits_nxt < CW'(FIFO_DEPTH));
        end
      endcase
    end
  end

  // Read pipeline: the RAM word is captured at accept, then delayed
  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign push      = rd_acc;
      assign push_data = rd_word;
    end else begin : g_latn
      logic [READ_LATENCY-2:0] sv;
      logic [DWIDTH-1:0]       sd [READ_LATENCY-1];

      always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
          sv <= '0;
        end else begin
          sv[0] <= rd_acc;
          for (int i = 1; i < READ_LATENCY - 1; i++) begin
            sv[i] <= sv[i-1];
          end
        end
      end

      always_ff @(posedge clk_i) begin
        sd[0] <= rd_word;
        for (int i = 1; i < READ_LATENCY - 1; i++) begin
          sd[i] <= sd[i-1];
        end
      end

      assign push      = sv[READ_LATENCY-2];
      assign push_data = sd[READ_LATENCY-2];
    end
  endgenerate

  // First-word-fall-through response FIFO; credits forbid overflow
  always_ff @(posedge clk_i) begin
    if (!srst_n_i) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo[i] <= '0;
      end
    end else begin
      if (push) begin
        fifo[wp] <= push_data;
        wp       <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_mem_responder.sv
// Directed bench for ext_mem_responder: latency 2 / depth 4 instance
// plus a latency 5 / depth 8 instance for the streaming case.
module tb_ext_mem_responder;

  logic clk = 1'b0;
  logic srst_n;
  int   vectors = 0;
  int   errors  = 0;

  always #5 clk = ~clk;

  ext_mem_responder_if #(.DWIDTH(16), .AWIDTH(4)) ifc ();
  ext_mem_responder_if #(.DWIDTH(16), .AWIDTH(4)) ifc5 ();

  ext_mem_responder #(
    .DWIDTH(16), .AWIDTH(4), .READ_LATENCY(2), .FIFO_DEPTH(4)
  ) dut (
    .clk_i    (clk),
    .srst_n_i (srst_n),
    .bus      (ifc.slave)
  );

  ext_mem_responder #(
    .DWIDTH(16), .AWIDTH(4), .READ_LATENCY(5), .FIFO_DEPTH(8)
  ) dut5 (
    .clk_i    (clk),
    .srst_n_i (srst_n),
    .bus      (ifc5.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifc.cmd_valid_i  = 1'b0;
    ifc.cmd_write_i  = 1'b0;
    ifc5.cmd_valid_i = 1'b0;
    ifc5.cmd_write_i = 1'b0;
  endtask

  initial begin
    int n;
    srst_n           = 1'b0;
    ifc.cmd_valid_i  = 1'b0;
    ifc.cmd_write_i  = 1'b0;
    ifc.cmd_addr_i   = '0;
    ifc.cmd_wdata_i  = '0;
    ifc.rd_ready_i   = 1'b0;
    ifc5.cmd_valid_i = 1'b0;
    ifc5.cmd_write_i = 1'b0;
    ifc5.cmd_addr_i  = '0;
    ifc5.cmd_wdata_i = '0;
    ifc5.rd_ready_i  = 1'b1;

    // Reset state
    step();
    step();
    chk("rst_ready", ifc.cmd_ready_o, 0);
    chk("rst_rvalid", ifc.rd_valid_o, 0);
    chk("rst_rdata", ifc.rd_data_o, 0);
    chk("rst_done", ifc.init_done_o, 0);

    // 1: clear sweep lasts 16 cycles
    srst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (ifc.cmd_ready_o === 1'b0 && ifc.init_done_o === 1'b0) n++;
      step();
    end
    chk("clear_cycles", n, 16);
    chk("serve_ready", ifc.cmd_ready_o, 1);
    chk("serve_done", ifc.init_done_o, 1);

    ifc.rd_ready_i  = 1'b1;
    ifc.cmd_valid_i = 1'b1;
    ifc.cmd_addr_i  = 4'd7;
    step();
    idle();
    chk("t1_rv_n1", ifc.rd_valid_o, 0);
    step();
    chk("t1_rv_n2", ifc.rd_valid_o, 1);
    chk("t1_data", ifc.rd_data_o, 16'h0000);
    step();

    // 2: write then read back
    ifc.cmd_valid_i = 1'b1;
    ifc.cmd_write_i = 1'b1;
    ifc.cmd_addr_i  = 4'd3;
    ifc.cmd_wdata_i = 16'h1234;
    step();
    ifc.cmd_write_i = 1'b0;
    step();
    idle();
    chk("t2_rv_n1", ifc.rd_valid_o, 0);
    step();
    chk("t2_rv_n2", ifc.rd_valid_o, 1);
    chk("t2_data", ifc.rd_data_o, 16'h1234);
    step();
    chk("t2_pulse_end", ifc.rd_valid_o, 0);

    // 3: credit limit with stalled initiator
    for (int i = 0; i < 4; i++) begin
      ifc.cmd_valid_i = 1'b1;
      ifc.cmd_write_i = 1'b1;
      ifc.cmd_addr_i  = 4'(8 + i);
      ifc.cmd_wdata_i = 16'(16'hA000 + i);
      step();
    end
    idle();
    ifc.rd_ready_i = 1'b0;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      ifc.cmd_valid_i = 1'b1;
      ifc.cmd_addr_i  = 4'(8 + (c % 4));
      chk($sformatf("t3_ready_c%0d", c), ifc.cmd_ready_o, (c < 4));
      if (ifc.cmd_ready_o === 1'b1) n++;
      step();
    end
    idle();
    chk("t3_accepted", n, 4);
    ifc.rd_ready_i = 1'b1;
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("t3_rv_%0d", j), ifc.rd_valid_o, 1);
      chk($sformatf("t3_data_%0d", j), ifc.rd_data_o, 16'hA000 + j);
      step();
    end
    chk("t3_empty", ifc.rd_valid_o, 0);
    chk("t3_ready_back", ifc.cmd_ready_o, 1);

    // 4: read-before-write ordering
    ifc.cmd_valid_i = 1'b1;
    ifc.cmd_addr_i  = 4'd5;
    step();
    ifc.cmd_write_i = 1'b1;
    ifc.cmd_wdata_i = 16'hBEEF;
    step();
    idle();
    chk("t4_old_rv", ifc.rd_valid_o, 1);
    chk("t4_old_data", ifc.rd_data_o, 16'h0000);
    step();
    ifc.cmd_valid_i = 1'b1;
    step();
    idle();
    step();
    chk("t4_new_rv", ifc.rd_valid_o, 1);
    chk("t4_new_data", ifc.rd_data_o, 16'hBEEF);
    step();

    // 5: streaming reads, latency 2
    for (int c = 0; c < 10; c++) begin
      if (c < 8) begin
        ifc.cmd_valid_i = 1'b1;
        ifc.cmd_addr_i  = 4'(8 + (c % 4));
        chk($sformatf("t5_ready_c%0d", c), ifc.cmd_ready_o, 1);
      end else begin
        ifc.cmd_valid_i = 1'b0;
      end
      chk($sformatf("t5_rv_c%0d", c), ifc.rd_valid_o, (c >= 2));
      if (c >= 2)
        chk($sformatf("t5_data_c%0d", c), ifc.rd_data_o,
            16'hA000 + ((c - 2) % 4));
      step();
    end
    idle();

    // 5b: streaming reads, latency 5
    for (int i = 0; i < 6; i++) begin
      ifc5.cmd_valid_i = 1'b1;
      ifc5.cmd_write_i = 1'b1;
      ifc5.cmd_addr_i  = 4'(i);
      ifc5.cmd_wdata_i = 16'(16'h5000 + i);
      step();
    end
    idle();
    for (int c = 0; c < 12; c++) begin
      if (c < 6) begin
        ifc5.cmd_valid_i = 1'b1;
        ifc5.cmd_addr_i  = 4'(c);
        chk($sformatf("t5b_ready_c%0d", c), ifc5.cmd_ready_o, 1);
      end else begin
        ifc5.cmd_valid_i = 1'b0;
      end
      chk($sformatf("t5b_rv_c%0d", c), ifc5.rd_valid_o, (c >= 5 && c < 11));
      if (c >= 5 && c < 11)
        chk($sformatf("t5b_data_c%0d", c), ifc5.rd_data_o, 16'h5000 + (c - 5));
      step();
    end
    idle();

    // 6: reset with reads outstanding
    ifc.rd_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      ifc.cmd_valid_i = 1'b1;
      ifc.cmd_addr_i  = 4'(8 + c);
      step();
    end
    idle();
    srst_n = 1'b0;
    step();
    chk("t6_rv", ifc.rd_valid_o, 0);
    chk("t6_ready", ifc.cmd_ready_o, 0);
    chk("t6_done", ifc.init_done_o, 0);
    chk("t6_data", ifc.rd_data_o, 0);
    srst_n = 1'b1;
    ifc.rd_ready_i = 1'b1;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      if (ifc.rd_valid_o !== 1'b0 || ifc.cmd_ready_o !== 1'b0) n++;
      step();
    end
    chk("t6_no_stale", n, 0);
    chk("t6_ready_back", ifc.cmd_ready_o, 1);
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin
        ifc.cmd_valid_i = 1'b1;
        ifc.cmd_addr_i  = 4'(c);
      end else begin
        ifc.cmd_valid_i = 1'b0;
      end
      if (c >= 2) begin
        chk($sformatf("t6_rv_a%0d", c - 2), ifc.rd_valid_o, 1);
        chk($sformatf("t6_zero_a%0d", c - 2), ifc.rd_data_o, 0);
      end
      step();
    end
    idle();
    chk("t6_drained", ifc.rd_valid_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
